// File: rtl/timer_pkg.sv
// Shared constants and mode encoding for the multi-rate timer.
// Holds the reference clock rate, the reset divider and the channel mode enum.
package timer_pkg;

   localparam int unsigned CLK_HZ      = 50000000;
   localparam int unsigned DEFAULT_DIV = 24999999;

   typedef enum logic {
      PERIODIC = 1'b0,
      ONE_SHOT = 1'b1
   } mode_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, terminal register, square/tick/done outputs.
// Ports: clk/rst_n, run_en (global and channel enable), mode, wr_en/wr_div
// (terminal-count load), sq_out/tick/done (registered outputs).
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned CNT_W   = 25,
   parameter int unsigned RST_DIV = DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_en,
   input  mode_e            mode,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_div,
   output logic             sq_out,
   output logic             tick,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             sq_q, sq_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      sq_d   = sq_q;
      tick_d = 1'b0;
      done_d = done_q;
      if (!run_en) begin
         cnt_d  = '0;
         sq_d   = 1'b0;
         done_d = 1'b0;
      end else if (wr_en) begin
         // a write beats a coinciding terminal count
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (!done_q) begin
         // >= recovers in one cycle if div shrank below cnt
         if (cnt_q >= div_q) begin
            cnt_d  = '0;
            sq_d   = ~sq_q;
            tick_d = 1'b1;
            done_d = (mode == ONE_SHOT);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (wr_en) begin
         div_d = wr_div;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         div_q  <= CNT_W'(RST_DIV);
         sq_q   <= 1'b0;
         tick_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         sq_q   <= sq_d;
         tick_q <= tick_d;
         done_q <= done_d;
      end
   end

   assign sq_out = sq_q;
   assign tick   = tick_q;
   assign done   = done_q;

endmodule

// File: rtl/multi_rate_timer.sv
// Multi-channel programmable timer: global gating and config decode only.
// Ports: clk_50_mhz, rst_n, enable_n, ch_en, one_shot, cfg_we/cfg_ch/cfg_div,
// sq_out/tick/done per channel.
module multi_rate_timer #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 25,
   parameter int unsigned DEFAULT_DIV = timer_pkg::DEFAULT_DIV
) (
   input  logic              clk_50_mhz,
   input  logic              rst_n,
   input  logic              enable_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] one_shot,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] sq_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] done
);

   logic [NUM_CH-1:0] run_en;
   logic [NUM_CH-1:0] wr_en;

   always_comb begin
      run_en = '0;
      wr_en  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         run_en[i] = !enable_n && ch_en[i];
         // out-of-range indices match no channel
         wr_en[i]  = cfg_we && (cfg_ch == 4'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_channel #(
         .CNT_W   (CNT_W),
         .RST_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk    (clk_50_mhz),
         .rst_n  (rst_n),
         .run_en (run_en[g]),
         .mode   (timer_pkg::mode_e'(one_shot[g])),
         .wr_en  (wr_en[g]),
         .wr_div (cfg_div),
         .sq_out (sq_out[g]),
         .tick   (tick[g]),
         .done   (done[g])
      );
   end

endmodule

// File: tb/tb_multi_rate_timer.sv
// Directed bench for multi_rate_timer (4 channels, reset divider 3).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_multi_rate_timer;

   localparam int NCH = 4;
   localparam int CW  = 8;

   logic          clk_50_mhz = 1'b0;
   logic          rst_n;
   logic          enable_n;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] one_shot;
   logic          cfg_we;
   logic [3:0]    cfg_ch;
   logic [CW-1:0] cfg_div;
   logic [NCH-1:0] sq_out;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] done;

   int n_cmp = 0;
   int n_bad = 0;

   multi_rate_timer #(
      .NUM_CH      (NCH),
      .CNT_W       (CW),
      .DEFAULT_DIV (3)
   ) dut (
      .clk_50_mhz (clk_50_mhz),
      .rst_n      (rst_n),
      .enable_n   (enable_n),
      .ch_en      (ch_en),
      .one_shot   (one_shot),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .sq_out     (sq_out),
      .tick       (tick),
      .done       (done)
   );

   always #10 clk_50_mhz = ~clk_50_mhz;

   task automatic step();
      @(posedge clk_50_mhz);
      @(negedge clk_50_mhz);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      enable_n = 1'b1;
      ch_en    = '0;
      one_shot = '0;
      cfg_we   = 1'b0;
      cfg_ch   = '0;
      cfg_div  = '0;
      repeat (3) @(negedge clk_50_mhz);
      n_cmp++;
      if ({sq_out, tick, done} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset: got %h want 000", {sq_out, tick, done});
      end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if ({sq_out, tick, done} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_idle: got %h want 000", {sq_out, tick, done});
      end
   endtask

   // divider 3 on channel 0: tick every 4, square period 8
   task automatic test_periodic();
      logic [3:0] et, es;
      enable_n = 1'b0;
      ch_en    = 4'b0001;
      for (int k = 1; k <= 16; k++) begin
         step();
         et = {3'b000, 1'((k % 4) == 0)};
         es = {3'b000, 1'((k / 4) % 2)};
         n_cmp++;
         if ({sq_out, tick, done} !== {es, et, 4'b0000}) begin
            n_bad++;
            $display("FAIL periodic k=%0d: got %h want %h", k,
                     {sq_out, tick, done}, {es, et, 4'b0000});
         end
      end
   endtask

   // divider 0 on channel 2: tick every cycle, square toggles every cycle
   task automatic test_div0();
      logic [3:0] et, es;
      ch_en = 4'b0000;
      step();
      cfg_we  = 1'b1;
      cfg_ch  = 4'd2;
      cfg_div = 8'd0;
      ch_en   = 4'b0100;
      for (int k = 1; k <= 9; k++) begin
         step();
         cfg_we = 1'b0;
         et = (k >= 2) ? 4'b0100 : 4'b0000;
         es = (((k - 1) % 2) == 1) ? 4'b0100 : 4'b0000;
         n_cmp++;
         if ({sq_out, tick, done} !== {es, et, 4'b0000}) begin
            n_bad++;
            $display("FAIL div0 k=%0d: got %h want %h", k,
                     {sq_out, tick, done}, {es, et, 4'b0000});
         end
      end
   endtask

   // one-shot on channel 1 with divider 5
   task automatic test_one_shot();
      logic [3:0] ev;
      ch_en = 4'b0000;
      step();
      cfg_we  = 1'b1;
      cfg_ch  = 4'd1;
      cfg_div = 8'd5;
      step();
      cfg_we   = 1'b0;
      ch_en    = 4'b0010;
      one_shot = 4'b0010;
      for (int k = 1; k <= 12; k++) begin
         step();
         ev = (k >= 6) ? 4'b0010 : 4'b0000;
         n_cmp++;
         if ({sq_out, tick, done} !==
             {ev, (k == 6) ? 4'b0010 : 4'b0000, ev}) begin
            n_bad++;
            $display("FAIL oneshot k=%0d: got %h want %h", k,
                     {sq_out, tick, done},
                     {ev, (k == 6) ? 4'b0010 : 4'b0000, ev});
         end
      end
      ch_en = 4'b0000;
      step();
      n_cmp++;
      if ({sq_out, tick, done} !== 12'h000) begin
         n_bad++;
         $display("FAIL oneshot_clear: got %h want 000",
                  {sq_out, tick, done});
      end
      ch_en = 4'b0010;
      for (int k = 1; k <= 7; k++) begin
         step();
         n_cmp++;
         if (tick[1] !== (k == 6)) begin
            n_bad++;
            $display("FAIL oneshot_rearm k=%0d: got %b want %b", k,
                     tick[1], (k == 6));
         end
      end
      one_shot = 4'b0000;
      ch_en    = 4'b0000;
      step();
   endtask

   // write lands on the terminal-count cycle of channel 0
   task automatic test_cfg_collision();
      ch_en = 4'b0001;
      for (int k = 1; k <= 7; k++) begin
         if (k == 4) begin
            cfg_we  = 1'b1;
            cfg_ch  = 4'd0;
            cfg_div = 8'd2;
         end
         step();
         cfg_we = 1'b0;
         n_cmp++;
         if ({sq_out[0], tick[0]} !== {1'(k == 7), 1'(k == 7)}) begin
            n_bad++;
            $display("FAIL collision k=%0d: got sq=%b tick=%b want %b",
                     k, sq_out[0], tick[0], (k == 7));
         end
      end
   endtask

   // enable_n keeps divider 2; rst_n brings back divider 3
   task automatic test_enable_reset();
      step();
      enable_n = 1'b1;
      step();
      n_cmp++;
      if ({sq_out, tick, done} !== 12'h000) begin
         n_bad++;
         $display("FAIL enable_off: got %h want 000", {sq_out, tick, done});
      end
      enable_n = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         n_cmp++;
         if ({sq_out[0], tick[0]} !== {1'(k == 3), 1'(k == 3)}) begin
            n_bad++;
            $display("FAIL enable_keep k=%0d: got sq=%b tick=%b want %b",
                     k, sq_out[0], tick[0], (k == 3));
         end
      end
      step();
      #5 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sq_out, tick, done} !== 12'h000) begin
         n_bad++;
         $display("FAIL async_reset: got %h want 000", {sq_out, tick, done});
      end
      @(negedge clk_50_mhz);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         n_cmp++;
         if (tick[0] !== (k == 4)) begin
            n_bad++;
            $display("FAIL reset_div k=%0d: got %b want %b", k,
                     tick[0], (k == 4));
         end
      end
   endtask

   // index 7 is out of range and must not touch channel 0
   task automatic test_bad_ch();
      ch_en = 4'b0000;
      step();
      ch_en   = 4'b0001;
      cfg_we  = 1'b1;
      cfg_ch  = 4'd7;
      cfg_div = 8'd0;
      for (int k = 1; k <= 5; k++) begin
         step();
         cfg_we = 1'b0;
         n_cmp++;
         if ({sq_out, tick} !== {3'b000, 1'(k >= 4), 3'b000, 1'(k == 4)}) begin
            n_bad++;
            $display("FAIL bad_ch k=%0d: got %h want %h", k, {sq_out, tick},
                     {3'b000, 1'(k >= 4), 3'b000, 1'(k == 4)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_div0();
      test_one_shot();
      test_cfg_collision();
      test_enable_reset();
      test_bad_ch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
